// File: rtl/mem_access.sv
// Memory-access pipeline stage: captures an execute-stage instruction, runs an
// optional data-memory transaction with timeout, then presents a one-cycle write-back.
module mem_access #(
   parameter int unsigned MEM_TIMEOUT = 15
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        ex_valid,
   output logic        ex_ready,
   input  logic [31:0] alu_data,
   input  logic [31:0] rd_data2,
   input  logic [31:0] branch_pc,
   input  logic        zero_flag,
   input  logic        mem_read,
   input  logic        mem_write,
   input  logic        branch,
   input  logic        mem_to_reg,
   input  logic        reg_write,
   input  logic [4:0]  write_reg,
   output logic        dmem_req,
   output logic        dmem_we,
   output logic [31:0] dmem_addr,
   output logic [31:0] dmem_wdata,
   input  logic [31:0] dmem_rdata,
   input  logic        dmem_ack,
   output logic        wb_valid,
   output logic        wb_we,
   output logic [4:0]  wb_reg,
   output logic [31:0] wb_data,
   output logic        branch_taken,
   output logic [31:0] branch_target,
   output logic        misalign,
   output logic        bus_err
);

   localparam int unsigned CW = 8;
   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] MEM  = 2'd1;
   localparam logic [1:0] DONE = 2'd2;

   logic [1:0]    state, state_nxt;
   logic [CW-1:0] cnt, cnt_nxt;
   logic          c_rd, c_wr, c_br, c_zf, c_m2r, c_rw;
   logic          c_rd_nxt, c_wr_nxt, c_br_nxt, c_zf_nxt, c_m2r_nxt, c_rw_nxt;
   logic [4:0]    c_reg, c_reg_nxt;
   logic [31:0]   c_alu, c_alu_nxt, c_wd, c_wd_nxt, c_bpc, c_bpc_nxt;
   logic [31:0]   rdata_q, rdata_nxt;
   logic          load_ok, load_ok_nxt, mis_q, mis_nxt, bus_q, bus_nxt;
   logic          accept, in_mem, in_done;

   assign accept  = ex_valid & (state != MEM);
   assign in_mem  = (state_nxt == MEM);
   assign in_done = (state_nxt == DONE);

   // Next-state and capture logic
   always_comb begin
      state_nxt   = state;
      cnt_nxt     = cnt;
      c_rd_nxt    = c_rd;
      c_wr_nxt    = c_wr;
      c_br_nxt    = c_br;
      c_zf_nxt    = c_zf;
      c_m2r_nxt   = c_m2r;
      c_rw_nxt    = c_rw;
      c_reg_nxt   = c_reg;
      c_alu_nxt   = c_alu;
      c_wd_nxt    = c_wd;
      c_bpc_nxt   = c_bpc;
      rdata_nxt   = rdata_q;
      load_ok_nxt = load_ok;
      mis_nxt     = mis_q;
      bus_nxt     = bus_q;
      case (state)
         IDLE, DONE: begin
            if (accept) begin
               c_rd_nxt    = mem_read;
               c_wr_nxt    = mem_write;
               c_br_nxt    = branch;
               c_zf_nxt    = zero_flag;
               c_m2r_nxt   = mem_to_reg;
               c_rw_nxt    = reg_write;
               c_reg_nxt   = write_reg;
               c_alu_nxt   = alu_data;
               c_wd_nxt    = rd_data2;
               c_bpc_nxt   = branch_pc;
               load_ok_nxt = 1'b0;
               mis_nxt     = 1'b0;
               bus_nxt     = 1'b0;
               cnt_nxt     = '0;
               state_nxt   = DONE;
               if (mem_read | mem_write) begin
                  if (alu_data[1:0] == 2'b00) begin
                     state_nxt = MEM;
                     cnt_nxt   = CW'(1);
                  end else begin
                     mis_nxt = 1'b1;
                  end
               end
            end else begin
               state_nxt = IDLE;
            end
         end
         MEM: begin
            // An ack on the final permitted cycle still counts as success
            if (dmem_ack) begin
               rdata_nxt   = dmem_rdata;
               load_ok_nxt = c_rd;
               cnt_nxt     = '0;
               state_nxt   = DONE;
            end else if (cnt == CW'(MEM_TIMEOUT)) begin
               bus_nxt   = 1'b1;
               cnt_nxt   = '0;
               state_nxt = DONE;
            end else begin
               cnt_nxt = cnt + CW'(1);
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state   <= IDLE;
         cnt     <= '0;
         c_rd    <= 1'b0;
         c_wr    <= 1'b0;
         c_br    <= 1'b0;
         c_zf    <= 1'b0;
         c_m2r   <= 1'b0;
         c_rw    <= 1'b0;
         c_reg   <= '0;
         c_alu   <= '0;
         c_wd    <= '0;
         c_bpc   <= '0;
         rdata_q <= '0;
         load_ok <= 1'b0;
         mis_q   <= 1'b0;
         bus_q   <= 1'b0;
      end else begin
         state   <= state_nxt;
         cnt     <= cnt_nxt;
         c_rd    <= c_rd_nxt;
         c_wr    <= c_wr_nxt;
         c_br    <= c_br_nxt;
         c_zf    <= c_zf_nxt;
         c_m2r   <= c_m2r_nxt;
         c_rw    <= c_rw_nxt;
         c_reg   <= c_reg_nxt;
         c_alu   <= c_alu_nxt;
         c_wd    <= c_wd_nxt;
         c_bpc   <= c_bpc_nxt;
         rdata_q <= rdata_nxt;
         load_ok <= load_ok_nxt;
         mis_q   <= mis_nxt;
         bus_q   <= bus_nxt;
      end
   end

   // Outputs registered from the next-cycle view of state and captured fields
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         ex_ready      <= 1'b1;
         dmem_req      <= 1'b0;
         dmem_we       <= 1'b0;
         dmem_addr     <= '0;
         dmem_wdata    <= '0;
         wb_valid      <= 1'b0;
         wb_we         <= 1'b0;
         wb_reg        <= '0;
         wb_data       <= '0;
         branch_taken  <= 1'b0;
         branch_target <= '0;
         misalign      <= 1'b0;
         bus_err       <= 1'b0;
      end else begin
         ex_ready      <= ~in_mem;
         dmem_req      <= in_mem;
         dmem_we       <= in_mem & c_wr_nxt;
         dmem_addr     <= in_mem ? c_alu_nxt : '0;
         dmem_wdata    <= in_mem ? c_wd_nxt : '0;
         wb_valid      <= in_done;
         wb_we         <= in_done & c_rw_nxt & ~mis_nxt & ~bus_nxt;
         wb_reg        <= in_done ? c_reg_nxt : '0;
         wb_data       <= !in_done ? '0 :
                          (c_m2r_nxt & load_ok_nxt) ? rdata_nxt : c_alu_nxt;
         branch_taken  <= in_done & c_br_nxt & c_zf_nxt;
         branch_target <= in_done ? c_bpc_nxt : '0;
         misalign      <= in_done & mis_nxt;
         bus_err       <= in_done & bus_nxt;
      end
   end

endmodule

// File: tb/tb_mem_access.sv
// Directed bench for mem_access: ALU, load, store, misalign, timeout, branch,
// back-to-back and reset-during-MEM scenarios with hand-computed expectations.
module tb_mem_access;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        ex_valid, ex_ready;
   logic [31:0] alu_data, rd_data2, branch_pc;
   logic        zero_flag, mem_read, mem_write, branch, mem_to_reg, reg_write;
   logic [4:0]  write_reg;
   logic        dmem_req, dmem_we, dmem_ack;
   logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
   logic        wb_valid, wb_we, branch_taken, misalign, bus_err;
   logic [4:0]  wb_reg;
   logic [31:0] wb_data, branch_target;

   int n_checks = 0;
   int n_errors = 0;
   int lo_cycles;

   mem_access #(.MEM_TIMEOUT(15)) dut (
      .clk(clk), .rst_n(rst_n), .ex_valid(ex_valid), .ex_ready(ex_ready),
      .alu_data(alu_data), .rd_data2(rd_data2), .branch_pc(branch_pc),
      .zero_flag(zero_flag), .mem_read(mem_read), .mem_write(mem_write),
      .branch(branch), .mem_to_reg(mem_to_reg), .reg_write(reg_write),
      .write_reg(write_reg), .dmem_req(dmem_req), .dmem_we(dmem_we),
      .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata), .dmem_rdata(dmem_rdata),
      .dmem_ack(dmem_ack), .wb_valid(wb_valid), .wb_we(wb_we), .wb_reg(wb_reg),
      .wb_data(wb_data), .branch_taken(branch_taken),
      .branch_target(branch_target), .misalign(misalign), .bus_err(bus_err)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_op(input logic mr, input logic mw, input logic br, input logic zf,
                         input logic m2r, input logic rw, input logic [4:0] wr,
                         input logic [31:0] alu, input logic [31:0] rd2,
                         input logic [31:0] bpc);
      ex_valid   = 1'b1;
      mem_read   = mr;
      mem_write  = mw;
      branch     = br;
      zero_flag  = zf;
      mem_to_reg = m2r;
      reg_write  = rw;
      write_reg  = wr;
      alu_data   = alu;
      rd_data2   = rd2;
      branch_pc  = bpc;
   endtask

   // Present one instruction for exactly one transfer cycle
   task automatic issue(input logic mr, input logic mw, input logic br, input logic zf,
                        input logic m2r, input logic rw, input logic [4:0] wr,
                        input logic [31:0] alu, input logic [31:0] rd2,
                        input logic [31:0] bpc);
      set_op(mr, mw, br, zf, m2r, rw, wr, alu, rd2, bpc);
      tick();
      ex_valid = 1'b0;
   endtask

   initial begin
      rst_n = 1'b0; ex_valid = 1'b0; dmem_ack = 1'b0; dmem_rdata = '0;
      set_op(0, 0, 0, 0, 0, 0, 5'd0, '0, '0, '0);
      ex_valid = 1'b0;
      tick(); tick();
      check("rst_ex_ready", 32'(ex_ready), 32'd1);
      check("rst_dmem_req", 32'(dmem_req), 32'd0);
      check("rst_wb_valid", 32'(wb_valid), 32'd0);
      check("rst_wb_data", wb_data, 32'd0);
      rst_n = 1'b1;
      tick();

      // Ack while idle is ignored
      dmem_ack = 1'b1; dmem_rdata = 32'hFFFF_FFFF;
      tick();
      dmem_ack = 1'b0;
      check("idle_ack_req", 32'(dmem_req), 32'd0);
      check("idle_ack_wbv", 32'(wb_valid), 32'd0);

      // ALU op
      issue(0, 0, 0, 0, 0, 1, 5'd5, 32'h0000_0042, '0, '0);
      check("alu_wb_valid", 32'(wb_valid), 32'd1);
      check("alu_wb_we", 32'(wb_we), 32'd1);
      check("alu_wb_reg", 32'(wb_reg), 32'd5);
      check("alu_wb_data", wb_data, 32'h42);
      check("alu_ex_ready", 32'(ex_ready), 32'd1);
      tick();
      check("alu_done_1cyc", 32'(wb_valid), 32'd0);

      // Load, ack on third request cycle
      issue(1, 0, 0, 0, 1, 1, 5'd7, 32'h0000_0100, 32'h5555_AAAA, '0);
      check("ld_req", 32'(dmem_req), 32'd1);
      check("ld_addr", dmem_addr, 32'h100);
      check("ld_we", 32'(dmem_we), 32'd0);
      lo_cycles = (ex_ready == 1'b0) ? 1 : 0;
      tick();
      if (ex_ready == 1'b0) lo_cycles++;
      check("ld_addr_stable", dmem_addr, 32'h100);
      tick();
      if (ex_ready == 1'b0) lo_cycles++;
      dmem_ack = 1'b1; dmem_rdata = 32'hDEAD_BEEF;
      tick();
      dmem_ack = 1'b0; dmem_rdata = '0;
      check("ld_ready_lo_cycles", 32'(lo_cycles), 32'd3);
      check("ld_wb_data", wb_data, 32'hDEAD_BEEF);
      check("ld_wb_we", 32'(wb_we), 32'd1);
      check("ld_wb_reg", 32'(wb_reg), 32'd7);
      check("ld_req_drop", 32'(dmem_req), 32'd0);
      tick();

      // Store with misaligned address
      issue(0, 1, 0, 0, 0, 1, 5'd3, 32'h0000_0102, 32'h1234_5678, '0);
      check("mis_req", 32'(dmem_req), 32'd0);
      check("mis_flag", 32'(misalign), 32'd1);
      check("mis_wb_valid", 32'(wb_valid), 32'd1);
      check("mis_wb_we", 32'(wb_we), 32'd0);
      tick();
      check("mis_pulse_end", 32'(misalign), 32'd0);

      // Aligned store: write enable and data presented
      issue(0, 1, 0, 0, 0, 0, 5'd0, 32'h0000_0200, 32'hCAFE_F00D, '0);
      check("st_we", 32'(dmem_we), 32'd1);
      check("st_wdata", dmem_wdata, 32'hCAFE_F00D);
      dmem_ack = 1'b1;
      tick();
      dmem_ack = 1'b0;
      check("st_done_we", 32'(wb_we), 32'd0);
      tick();

      // Load timeout: 15 request cycles then abort
      issue(1, 0, 0, 0, 1, 1, 5'd9, 32'h0000_0300, '0, '0);
      lo_cycles = 0;
      for (int i = 0; i < 15; i++) begin
         if (dmem_req) lo_cycles++;
         tick();
      end
      check("to_req_cycles", 32'(lo_cycles), 32'd15);
      check("to_bus_err", 32'(bus_err), 32'd1);
      check("to_wb_valid", 32'(wb_valid), 32'd1);
      check("to_wb_we", 32'(wb_we), 32'd0);
      check("to_wb_data", wb_data, 32'h300);
      check("to_req_drop", 32'(dmem_req), 32'd0);
      tick();
      check("to_pulse_end", 32'(bus_err), 32'd0);

      // Ack on the 15th cycle is a success
      issue(1, 0, 0, 0, 1, 1, 5'd10, 32'h0000_0400, '0, '0);
      for (int i = 0; i < 14; i++) tick();
      check("a15_still_req", 32'(dmem_req), 32'd1);
      dmem_ack = 1'b1; dmem_rdata = 32'h1234_5678;
      tick();
      dmem_ack = 1'b0;
      check("a15_bus_err", 32'(bus_err), 32'd0);
      check("a15_wb_we", 32'(wb_we), 32'd1);
      check("a15_wb_data", wb_data, 32'h1234_5678);
      tick();

      // Branch taken and not taken
      issue(0, 0, 1, 1, 0, 0, 5'd0, 32'h0, '0, 32'h0040_0020);
      check("br_taken", 32'(branch_taken), 32'd1);
      check("br_target", branch_target, 32'h0040_0020);
      tick();
      check("br_one_cycle", 32'(branch_taken), 32'd0);
      issue(0, 0, 1, 0, 0, 0, 5'd0, 32'h0, '0, 32'h0040_0020);
      check("br_not_taken", 32'(branch_taken), 32'd0);
      tick();

      // Back-to-back transfers through DONE
      set_op(0, 0, 0, 0, 0, 1, 5'd1, 32'h0000_0011, '0, '0);
      tick();
      check("b2b_ready", 32'(ex_ready), 32'd1);
      set_op(0, 0, 0, 0, 0, 1, 5'd2, 32'h0000_0022, '0, '0);
      tick();
      ex_valid = 1'b0;
      check("b2b_wb_valid", 32'(wb_valid), 32'd1);
      check("b2b_wb_reg", 32'(wb_reg), 32'd2);
      check("b2b_wb_data", wb_data, 32'h22);
      tick();

      // Reset on the second MEM cycle, late ack afterwards
      issue(1, 0, 0, 0, 1, 1, 5'd4, 32'h0000_0500, '0, '0);
      tick();
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      dmem_ack = 1'b1; dmem_rdata = 32'hBAD0_BAD0;
      check("rmem_req", 32'(dmem_req), 32'd0);
      check("rmem_ready", 32'(ex_ready), 32'd1);
      check("rmem_wbv", 32'(wb_valid), 32'd0);
      tick();
      dmem_ack = 1'b0;
      check("rmem_late_ack", 32'(wb_valid), 32'd0);
      check("rmem_late_req", 32'(dmem_req), 32'd0);
      tick();

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/mem_access.md
MEM_ACCESS -- requirements
Module: mem_access

Interface
REQ-001 Parameter MEM_TIMEOUT, default 15: max cycles dmem_req held without dmem_ack before abort (legal 2..255).
REQ-002 clk  in  1  sole clock; all state updates on rising edge.
REQ-003 rst_n  in  1  reset, synchronous, active-low.
REQ-004 ex_valid  in  1  execute stage presents a valid instruction.
REQ-005 ex_ready  out  1  stage can accept; transfer occurs on a cycle with ex_valid & ex_ready.
REQ-006 alu_data  in  32  ALU result; memory byte address for loads/stores.
REQ-007 rd_data2  in  32  store data.
REQ-008 branch_pc  in  32  computed branch target; zero_flag  in  1  ALU zero result.
REQ-009 mem_read, mem_write, branch, mem_to_reg, reg_write  in  1 each  control bits; write_reg  in  5  destination register.
REQ-010 dmem_req, dmem_we  out  1; dmem_addr, dmem_wdata  out  32; dmem_rdata  in  32; dmem_ack  in  1  data-memory port.
REQ-011 wb_valid  out  1; wb_we  out  1; wb_reg  out  5; wb_data  out  32  write-back result.
REQ-012 branch_taken  out  1; branch_target  out  32  branch resolution.
REQ-013 misalign, bus_err  out  1 each  single-cycle error pulses.

Function
REQ-014 FSM states IDLE, MEM, DONE; ex_ready SHALL be 1 in IDLE and DONE, 0 in MEM.
REQ-015 On transfer, all inputs SHALL be captured into internal registers; outputs derive only from captured values.
REQ-016 Transfer with mem_read=mem_write=0 SHALL go to DONE next cycle (1-cycle latency), wb_data=captured alu_data.
REQ-017 Transfer with mem_read|mem_write and alu_data[1:0]=0 SHALL go to MEM; dmem_req=1 from the next cycle.
REQ-018 In MEM, dmem_addr, dmem_wdata, dmem_we (=captured mem_write) SHALL stay stable until the ack cycle.
REQ-019 On a MEM cycle with dmem_ack=1, dmem_rdata SHALL be latched, dmem_req deasserted next cycle, state to DONE.
REQ-020 Timeout counter SHALL be 1 on the first MEM cycle, +1 per MEM cycle; counter=MEM_TIMEOUT with dmem_ack=0 SHALL abort to DONE.
REQ-021 dmem_ack on the same cycle the counter reaches MEM_TIMEOUT SHALL count as success, not abort.
REQ-022 Mem op with alu_data[1:0]!=0 SHALL issue no dmem_req and go to DONE.
REQ-023 misalign (misalignment) or bus_err (abort) SHALL pulse high exactly in the DONE cycle; wb_we forced 0 there.
REQ-024 DONE SHALL last one cycle: wb_valid=1, wb_reg=captured write_reg, wb_we=captured reg_write unless REQ-023.
REQ-025 wb_data in DONE SHALL be latched dmem_rdata when mem_to_reg=1 and load succeeded, else captured alu_data.
REQ-026 branch_taken SHALL be 1 only in DONE when captured branch & zero_flag; branch_target=captured branch_pc.
REQ-027 Transfer while in DONE SHALL be accepted (back-to-back); DONE->DONE or DONE->MEM per REQ-016/017/022; with no transfer DONE->IDLE.
REQ-028 dmem_ack outside MEM SHALL be ignored.
REQ-029 wb_valid, branch_taken, misalign, bus_err SHALL be 0 outside DONE.

Reset
REQ-030 rst_n=0 at a rising edge SHALL force IDLE, counter 0, all outputs 0 except ex_ready=1, regardless of state.
REQ-031 Reset during MEM SHALL drop dmem_req the following cycle; a late dmem_ack SHALL produce no write-back.

Verification
REQ-032 ALU op alu_data=0x0000_0042, reg_write=1, write_reg=5 -> next cycle wb_valid=1, wb_we=1, wb_reg=5, wb_data=0x42.
REQ-033 Load addr 0x100, ack on 3rd req cycle with rdata=0xDEAD_BEEF, mem_to_reg=1 -> ex_ready 0 for 3 cycles, wb_data=0xDEADBEEF one cycle after ack.
REQ-034 Store addr 0x102 -> no dmem_req, misalign=1 and wb_valid=1 with wb_we=0 next cycle.
REQ-035 Load, MEM_TIMEOUT=15, ack never -> dmem_req high 15 cycles, then bus_err=1, wb_we=0; ack at cycle 15 instead -> success.
REQ-036 Branch, zero_flag=1, branch_pc=0x0040_0020 -> branch_taken=1, branch_target=0x00400020 one cycle; zero_flag=0 -> branch_taken=0.
REQ-037 rst_n=0 on 2nd MEM cycle, ack asserted after -> IDLE, dmem_req=0, wb_valid stays 0.
